// File: rtl/tfhe_keygen_pkg.sv
// tfhe_keygen_pkg: shared defaults, requester ids and controller FSM encoding for the TFHE keygen path
package tfhe_keygen_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_TO_WIDTH = 8;
  localparam logic REQ_BSK = 1'b0;
  localparam logic REQ_KSK = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } gp_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant (clk, rst active-low async, en, req[1:0] -> gnt_vld, gnt_id); a tie goes to the requester not granted last
module rr_arbiter2
  import tfhe_keygen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_id
);
  logic last_grant;
  assign gnt_vld = en && |req;
  assign gnt_id = &req ? !last_grant : req[1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= REQ_KSK;
    else if (gnt_vld) last_grant <= gnt_id;
endmodule

// File: rtl/gadget_precompute_ctrl.sv
// gadget_precompute_ctrl: shares PreCompute128 between req0/req1 (valid/ready, Bg/Q in; resp0/1_valid, GPow0..2, err out) with a one-entry result cache, pc_* engine handshake and a saturating completion timeout
module gadget_precompute_ctrl
  import tfhe_keygen_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_WIDTH       = DEF_TO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req0_Bg,
  input  logic [DATA_WIDTH-1:0] req0_Q,
  input  logic [DATA_WIDTH-1:0] req1_Bg,
  input  logic [DATA_WIDTH-1:0] req1_Q,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp_GPow0,
  output logic [DATA_WIDTH-1:0] resp_GPow1,
  output logic [DATA_WIDTH-1:0] resp_GPow2,
  output logic                  resp_err,
  input  logic                  flush,
  output logic                  pc_start,
  output logic [DATA_WIDTH-1:0] pc_Bg,
  output logic [DATA_WIDTH-1:0] pc_Q,
  input  logic [DATA_WIDTH-1:0] pc_GPow0,
  input  logic [DATA_WIDTH-1:0] pc_GPow1,
  input  logic [DATA_WIDTH-1:0] pc_GPow2,
  input  logic                  pc_ready,
  input  logic                  pc_done
);
  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT_CYCLES);
  gp_state_t state, state_nx;
  logic gnt_vld, gnt_id, gid, hit, tmo, wait_done, wait_tmo, err_r, cache_vld, fl_r;
  logic [DATA_WIDTH-1:0] sel_bg, sel_q, bg_r, q_r, c_bg, c_q;
  logic [2:0][DATA_WIDTH-1:0] c_g, r_g, pc_g;
  logic [TO_WIDTH-1:0] cnt;
  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (rst && state == S_IDLE),
    .req    ({req1_valid, req0_valid}),
    .gnt_vld(gnt_vld),
    .gnt_id (gnt_id)
  );
  assign pc_g = {pc_GPow2, pc_GPow1, pc_GPow0};
  assign sel_bg = gnt_id ? req1_Bg : req0_Bg;
  assign sel_q = gnt_id ? req1_Q : req0_Q;
  assign hit = cache_vld && !flush && sel_bg == c_bg && sel_q == c_q;
  assign tmo = cnt == TO_MAX;
  assign wait_done = state == S_WAIT && pc_done;
  assign wait_tmo = state == S_WAIT && !pc_done && tmo;
  assign {resp_GPow2, resp_GPow1, resp_GPow0} = r_g;
  assign pc_Bg = bg_r;
  assign pc_Q = q_r;
  always_comb begin
    state_nx = state == S_IDLE   ? (gnt_vld ? (hit ? S_RESP : S_LAUNCH) : S_IDLE)
             : state == S_LAUNCH ? (pc_ready ? S_WAIT : S_LAUNCH)
             : state == S_WAIT   ? (pc_done || tmo ? S_RESP : S_WAIT)
             : S_IDLE;
    req0_ready = gnt_vld && gnt_id == REQ_BSK;
    req1_ready = gnt_vld && gnt_id == REQ_KSK;
    pc_start = state == S_LAUNCH && pc_ready;
    resp0_valid = state == S_RESP && gid == REQ_BSK;
    resp1_valid = state == S_RESP && gid == REQ_KSK;
    resp_err = state == S_RESP && err_r;
  end
  // fl_r remembers a flush seen since the grant so a completing launch does not revalidate a flushed cache
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      gid <= 1'b0;
      bg_r <= '0;
      q_r <= '0;
      r_g <= '0;
      err_r <= 1'b0;
      cache_vld <= 1'b0;
      c_bg <= '0;
      c_q <= '0;
      c_g <= '0;
      fl_r <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == S_WAIT ? cnt + TO_WIDTH'(!tmo) : '0;
      cache_vld <= flush ? 1'b0 : wait_done ? !fl_r : wait_tmo ? 1'b0 : cache_vld;
      fl_r <= flush || (!gnt_vld && fl_r);
      if (gnt_vld) begin
        gid <= gnt_id;
        bg_r <= sel_bg;
        q_r <= sel_q;
        r_g <= c_g;
        err_r <= 1'b0;
      end
      if (wait_done) begin
        r_g <= pc_g;
        c_g <= pc_g;
        c_bg <= bg_r;
        c_q <= q_r;
        err_r <= 1'b0;
      end else if (wait_tmo) begin
        r_g <= '0;
        err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gadget_precompute_ctrl.sv
// tb_gadget_precompute_ctrl: directed plan plus randomized traffic against a transaction-level model of the precompute controller
module tb_gadget_precompute_ctrl;
  localparam int TMO = 255;
  localparam logic [31:0] P_BG = 32'h0020_0000;
  localparam logic [31:0] P_Q = 32'h7FFF_F000;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req1_valid = 0, flush = 0, pc_ready = 1, pc_done = 0;
  logic [31:0] req0_Bg = 0, req0_Q = 0, req1_Bg = 0, req1_Q = 0;
  logic [31:0] pc_GPow0 = 0, pc_GPow1 = 0, pc_GPow2 = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, pc_start;
  logic [31:0] resp_GPow0, resp_GPow1, resp_GPow2, pc_Bg, pc_Q;
  gadget_precompute_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_Bg(req0_Bg), .req0_Q(req0_Q), .req1_Bg(req1_Bg), .req1_Q(req1_Q),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_GPow0(resp_GPow0), .resp_GPow1(resp_GPow1), .resp_GPow2(resp_GPow2),
    .resp_err(resp_err), .flush(flush), .pc_start(pc_start),
    .pc_Bg(pc_Bg), .pc_Q(pc_Q),
    .pc_GPow0(pc_GPow0), .pc_GPow1(pc_GPow1), .pc_GPow2(pc_GPow2),
    .pc_ready(pc_ready), .pc_done(pc_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  // model state: one outstanding transaction plus the cached parameter set
  bit pend = 0, p_id, p_hit, p_started, p_done, p_fl, mvld = 0, mlast = 1;
  int p_g, p_s, p_dcyc, p_nst, resp_cyc = -10;
  logic [31:0] p_bg, p_q, mbg, mq;
  logic [2:0][31:0] p_res, p_exp, mg, ed, last_g;
  bit exp_rv, exp_st, can, eg0, eg1, acc0 = 0, acc1 = 0, last_id, last_err;
  int n_start = 0, n_resp = 0;
  bit rq[$];
  bit eng_busy = 0, rmode = 0;
  int eng_at = 0, eng_lat = 6;
  logic [31:0] pool_bg[5], pool_q[5];
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pend = 0; mvld = 0; mlast = 1; acc0 = 0; acc1 = 0;
    end else begin
      if (pend && !p_hit && cyc > p_g) begin
        chk("pc_Bg", pc_Bg, p_bg);
        chk("pc_Q", pc_Q, p_q);
      end
      exp_rv = pend && (p_hit ? cyc == p_g + 1 : p_started && (p_done ? cyc == p_dcyc + 1 : cyc == p_s + TMO + 2));
      chk("resp0_valid", resp0_valid, exp_rv && !p_id);
      chk("resp1_valid", resp1_valid, exp_rv && p_id);
      if (exp_rv) begin
        ed = p_hit ? p_exp : p_done ? p_res : '0;
        chk("resp_err", resp_err, !p_hit && !p_done);
        chk("GPow0", resp_GPow0, ed[0]);
        chk("GPow1", resp_GPow1, ed[1]);
        chk("GPow2", resp_GPow2, ed[2]);
        chk("launches", p_nst, p_hit ? 0 : 1);
        if (!p_hit) begin
          if (p_done && !p_fl) begin mvld = 1; mbg = p_bg; mq = p_q; mg = p_res; end
          else mvld = 0;
        end
        last_id = p_id; last_err = resp_err; last_g = {resp_GPow2, resp_GPow1, resp_GPow0};
        n_resp++; rq.push_back(p_id);
        pend = 0; resp_cyc = cyc;
      end
      exp_st = pend && !p_hit && !p_started && cyc > p_g && pc_ready;
      chk("pc_start", pc_start, exp_st);
      if (pc_start) begin
        n_start++; p_nst++;
        eng_busy = eng_lat != 0; eng_at = cyc + eng_lat;
      end
      if (exp_st) begin p_started = 1; p_s = cyc; end
      if (pend && p_started && !p_done && pc_done && cyc > p_s && cyc <= p_s + TMO + 1) begin
        p_done = 1; p_dcyc = cyc; p_res = {pc_GPow2, pc_GPow1, pc_GPow0};
      end
      if (flush) begin
        mvld = 0;
        if (pend && p_started) p_fl = 1;
      end
      can = !pend && cyc != resp_cyc;
      eg0 = can && req0_valid && (!req1_valid || mlast);
      eg1 = can && req1_valid && (!req0_valid || !mlast);
      chk("req0_ready", req0_ready, eg0);
      chk("req1_ready", req1_ready, eg1);
      if (eg0 || eg1) begin
        p_id = eg1; mlast = eg1; acc0 = eg0; acc1 = eg1;
        p_bg = eg1 ? req1_Bg : req0_Bg;
        p_q = eg1 ? req1_Q : req0_Q;
        p_hit = mvld && !flush && p_bg == mbg && p_q == mq;
        p_exp = mg; pend = 1; p_g = cyc;
        p_started = 0; p_done = 0; p_fl = 0; p_nst = 0;
      end
    end
  end
  task automatic tick();
    int k;
    @(posedge clk); #1;
    flush = 0;
    if (acc0) begin req0_valid = 0; acc0 = 0; end
    if (acc1) begin req1_valid = 0; acc1 = 0; end
    pc_done = eng_busy && cyc == eng_at;
    if (pc_done) begin
      eng_busy = 0;
      {pc_GPow2, pc_GPow1, pc_GPow0} = (pc_Bg == P_BG && pc_Q == P_Q) ? {32'd4194304, 32'd2048, 32'd1}
                                                                       : {~pc_Q, pc_Bg + 32'd1, pc_Bg ^ pc_Q};
    end else {pc_GPow2, pc_GPow1, pc_GPow0} = {$urandom, $urandom, $urandom};
    pc_ready = !rmode || $urandom_range(0, 4) != 0;
    if (rmode) begin
      if (!req0_valid && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 4); req0_valid = 1; req0_Bg = pool_bg[k]; req0_Q = pool_q[k];
      end
      if (!req1_valid && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 4); req1_valid = 1; req1_Bg = pool_bg[k]; req1_Q = pool_q[k];
      end
      flush = !pend && !req0_valid && !req1_valid && $urandom_range(0, 19) == 0;
      eng_lat = $urandom_range(0, 49) == 0 ? 0 : $urandom_range(1, 12);
    end
  endtask
  task automatic req(input bit id, input logic [31:0] bg, input logic [31:0] q, input int lat);
    eng_lat = lat;
    if (id) begin req1_valid = 1; req1_Bg = bg; req1_Q = q; end
    else begin req0_valid = 1; req0_Bg = bg; req0_Q = q; end
  endtask
  task automatic wait_quiet(input int max);
    int n = 0;
    while ((pend || req0_valid || req1_valid) && n < max) begin tick(); n++; end
    if (n >= max) chk("quiet_bound", 1, 0);
  endtask
  task automatic wait_started(input int max);
    int n = 0;
    while (!(pend && p_started) && n < max) begin tick(); n++; end
    if (n >= max) chk("start_bound", 1, 0);
  endtask
  task automatic check_zero(input string t);
    chk({t, ":req0_ready"}, req0_ready, 0);
    chk({t, ":req1_ready"}, req1_ready, 0);
    chk({t, ":resp0_valid"}, resp0_valid, 0);
    chk({t, ":resp1_valid"}, resp1_valid, 0);
    chk({t, ":resp_err"}, resp_err, 0);
    chk({t, ":pc_start"}, pc_start, 0);
    chk({t, ":GPow0"}, resp_GPow0, 0);
    chk({t, ":GPow1"}, resp_GPow1, 0);
    chk({t, ":GPow2"}, resp_GPow2, 0);
    chk({t, ":pc_Bg"}, pc_Bg, 0);
    chk({t, ":pc_Q"}, pc_Q, 0);
  endtask
  initial begin
    int s, r;
    for (int i = 0; i < 4; i++) begin pool_bg[i] = $urandom; pool_q[i] = $urandom; end
    pool_bg[4] = P_BG; pool_q[4] = P_Q;
    req0_valid = 1;
    #2 check_zero("reset");
    req0_valid = 0;
    repeat (3) tick();
    rst = 1;
    repeat (2) tick();
    s = n_start; r = n_resp;
    req(0, P_BG, P_Q, 6);
    wait_quiet(100);
    chk("t1_launch", n_start - s, 1);
    chk("t1_resp", n_resp - r, 1);
    chk("t1_id", last_id, 0);
    chk("t1_err", last_err, 0);
    chk("t1_g0", last_g[0], 1);
    chk("t1_g1", last_g[1], 2048);
    chk("t1_g2", last_g[2], 4194304);
    s = n_start;
    req(1, P_BG, P_Q, 6);
    wait_quiet(100);
    chk("t2_launch", n_start - s, 0);
    chk("t2_id", last_id, 1);
    chk("t2_g1", last_g[1], 2048);
    chk("t2_g2", last_g[2], 4194304);
    s = n_start; rq.delete();
    req(0, P_BG, 32'h1111_0000, 4);
    req(1, P_BG, 32'h2222_0000, 4);
    wait_quiet(100);
    chk("t3_launch", n_start - s, 2);
    chk("t3_nresp", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("t3_first", rq[0], 0);
      chk("t3_second", rq[1], 1);
    end
    req(0, 32'hA5A5_0001, 32'h0BAD_F00D, 0);
    wait_quiet(400);
    chk("t4_err", last_err, 1);
    chk("t4_g", last_g, 0);
    s = n_start;
    req(0, 32'hA5A5_0001, 32'h0BAD_F00D, 3);
    wait_quiet(100);
    chk("t4_relaunch", n_start - s, 1);
    chk("t4_err_after", last_err, 0);
    r = n_resp;
    req(0, 32'hC0DE_0002, 32'h0000_1234, 10);
    wait_started(20);
    repeat (3) tick();
    flush = 1;
    wait_quiet(100);
    chk("t5_resp", n_resp - r, 1);
    chk("t5_err", last_err, 0);
    s = n_start;
    req(0, 32'hC0DE_0002, 32'h0000_1234, 3);
    wait_quiet(100);
    chk("t5_relaunch", n_start - s, 1);
    req(1, 32'hBEEF_0003, 32'h0000_5678, 20);
    wait_started(20);
    repeat (3) tick();
    s = n_start; r = n_resp;
    rst = 0; req0_valid = 0; req1_valid = 0;
    #1 check_zero("midrst");
    repeat (2) tick();
    rst = 1;
    repeat (30) tick();
    chk("t6_no_resp", n_resp - r, 0);
    chk("t6_no_start", n_start - s, 0);
    req(0, 32'h5555_0004, 32'h0000_0100, 256);
    wait_quiet(400);
    chk("t7_done_wins", last_err, 0);
    chk("t7_g0", last_g[0], 32'h5555_0004 ^ 32'h0000_0100);
    req(0, 32'h5555_0004, 32'h0000_0200, 257);
    wait_quiet(400);
    chk("t7_timeout", last_err, 1);
    r = n_resp;
    rmode = 1;
    repeat (3000) tick();
    rmode = 0;
    wait_quiet(1000);
    chk("rand_activity", n_resp - r > 50, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gadget_precompute_ctrl.md
# gadget_precompute_ctrl

Sequencing and sharing controller for the gadget-power precompute engine (`PreCompute128`) in the TFHE key-generation path. Two requesters submit (Bg, Q) parameter sets:
- requester 0: bootstrapping-key generator;
- requester 1: key-switching-key generator.

The controller arbitrates round-robin, launches the engine only when the parameters differ from the cached last result, enforces a completion timeout, and returns GPow0..GPow2 to the granted requester.

## Interface
- DATA_WIDTH, 32, width of Bg, Q and GPow words (signed)
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for engine `done`
- TO_WIDTH, 8, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1  request pending; must be held with data until the matching reqN_ready
- req0_Bg, req0_Q, req1_Bg, req1_Q  in  DATA_WIDTH  request parameters
- req0_ready, req1_ready  out  1  one-cycle accept pulse
- resp0_valid, resp1_valid  out  1  one-cycle completion pulse to the granted requester
- resp_GPow0, resp_GPow1, resp_GPow2  out  DATA_WIDTH  result; valid while respN_valid is high
- resp_err  out  1  qualifies respN_valid; 1 = timeout, GPow outputs are 0
- flush  in  1  invalidate cache
- pc_start  out  1  engine start pulse
- pc_Bg, pc_Q  out  DATA_WIDTH  engine operands; held from LAUNCH through WAIT
- pc_GPow0, pc_GPow1, pc_GPow2  in  DATA_WIDTH  engine results
- pc_ready, pc_done  in  1  engine status

## Operation
- **FSM states:** IDLE, LAUNCH, WAIT, RESP.
- **IDLE arbitration:**
  - One request valid: grant it.
  - Both valid: grant the requester other than `last_grant`.
  - On grant: pulse reqN_ready, latch Bg/Q and the grant id, update `last_grant`.
- **Cache check (same cycle as grant):** compare the latched-to-be Bg/Q with the cache tag (`cache_vld`, `cache_Bg`, `cache_Q`).
  - Hit: next state RESP, data taken from the cache.
  - Miss: next state LAUNCH.
- **LAUNCH:** assert pc_start for exactly one cycle, only when pc_ready = 1, then go to WAIT. Otherwise stay in LAUNCH with pc_start = 0. The timeout counter does not run in LAUNCH.
- **WAIT:**
  - The counter increments every cycle.
  - pc_done = 1: latch pc_GPow0..2 into the result and the cache, set cache_vld, go to RESP with err = 0.
  - Counter reaches TIMEOUT_CYCLES with no done: result = 0, err = 1, cache_vld cleared, go to RESP.
  - pc_done and timeout in the same cycle: done wins.
- **RESP:** pulse resp_valid for the granted id, drive the result and err, return to IDLE. No new grant is issued in this cycle.
- **pc_done outside WAIT:** ignored.
- **flush:**
  - Clears cache_vld in any state.
  - If flush is high during WAIT, or in the same cycle as pc_done, the result is still returned but cache_vld remains 0.
  - If flush coincides with an IDLE cache check, the check is treated as a miss.
- **Width rule:** pure register moves; no arithmetic except the TO_WIDTH counter, which saturates and never wraps.

## Timing
- **Reset (rst low, asynchronous):**
  - All outputs are 0.
  - FSM goes to IDLE, `last_grant` = 1 (so requester 0 wins the first tie), cache_vld = 0, counter = 0.
  - Reset mid-operation abandons the request; no response is issued.
- **Cache hit:** grant at cycle T, resp_valid at T+1 (latency 1).
- **Miss with pc_ready high:** grant at T, pc_start at T+1, WAIT from T+2. If pc_done is seen at cycle D, resp_valid is at D+1.
- **Back-to-back:** a request pending during RESP is granted at the following IDLE cycle. Minimum spacing between grants is 2 cycles.
- **Timeout:** resp_err asserts TIMEOUT_CYCLES+1 cycles after the first WAIT cycle.

## Structure
- A shared package `tfhe_keygen_pkg` holds:
  - FSM state encoding (2-bit localparams);
  - default DATA_WIDTH / TIMEOUT_CYCLES constants;
  - requester id constants.
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin arbiter with grant/last_grant register. It is combinational grant logic plus a pointer update on accept.
- The cache, FSM and timeout counter live in the top module.

## Test plan
- Reset, then req0 with Bg = 32'h0020_0000, Q = 32'h7FFF_F000. Mock engine asserts done 6 cycles after start with GPow = 1, 2048, 4194304. Required: exactly one pc_start; resp0_valid 1 cycle after done with those values; err = 0.
- Repeat the identical req1 request. Required: no pc_start; resp1_valid 1 cycle after the grant with the cached values.
- req0 and req1 valid in the same cycle with different Q. Required: req0 granted first (reset tie-break), req1 next; two launches; responses in grant order.
- Mock engine never asserts done, TIMEOUT_CYCLES = 255. Required: resp_err = 1 with GPow = 0 at cycle 256 of WAIT. A subsequent identical request must relaunch the engine (cache invalid).
- flush during WAIT. Required: the response is still delivered. The same request afterwards must relaunch the engine.
- rst low during WAIT. Required: all outputs are 0 immediately; no response. A late pc_done after reset release is ignored.
